def_cmd_sched: RTL and testbench

Command scheduler for the two defectoscope control transmitters. It accepts 32-bit commands from the NIOS command port, queues them per channel, and merges them with periodic status-poll commands. It then drives each channel's valid/ready transmitter handshake on the system clock; the clkx-domain crossing sits downstream. It is instantiated in the top level between the NIOS command bus and the transmitter inputs (`cntr_data`, `cntr_valid`, `cntrtr_ready`).

---
 rtl/def_ctrl_pkg.sv | 10 +
 rtl/def_cmd_fifo.sv | 68 ++++++
 rtl/def_cmd_sched.sv | 177 +++++++++++++++++
 tb/tb_def_cmd_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/def_ctrl_pkg.sv
// Shared types and constants for the defectoscope command scheduler.
package def_ctrl_pkg;

  localparam int DEF_CMD_W = 32;
  localparam logic [DEF_CMD_W-1:0] DEF_POLL_CMD = 32'hA500_0000;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} sched_st_t;
  typedef enum logic {SRC_HOST = 1'b0, SRC_POLL = 1'b1} sched_src_t;

endpackage

// File: rtl/def_cmd_fifo.sv
// Synchronous show-ahead FIFO with a registered full flag; pushes while full are ignored.
module def_cmd_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          do_push_s, do_pop_s;

  // Next-state for pointers, occupancy and full flag
  always_comb begin
    do_push_s = push_i & ~full_q;
    do_pop_s  = pop_i & (cnt_q != CNT_ZERO);
    wr_ptr_d  = do_push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == CNT_DEPTH);
  end

  // Pointer, count and full-flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= CNT_ZERO;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == CNT_ZERO);
  assign full_o  = full_q;

endmodule

// File: rtl/def_cmd_sched.sv
// Two-channel command scheduler: host queues merged with periodic polls onto valid/ready transmitters.
// Define DEF_POLL_EN to build the poll timer and poll/host round-robin arbitration.
module def_cmd_sched
  import def_ctrl_pkg::*;
#(
  parameter int                   FIFO_DEPTH = 8,
  parameter int                   POLL_DIV   = 50000,
  parameter logic [DEF_CMD_W-1:0] POLL_CMD   = DEF_POLL_CMD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_cmd_wr,
  input  logic                 i_cmd_ch,
  input  logic [DEF_CMD_W-1:0] i_cmd_data,
  output logic [1:0]           o_cmd_full,
  output logic                 o_drop,
  input  logic                 i_poll_en,
  output logic                 o_poll_ovr,
  output logic [DEF_CMD_W-1:0] o_cntr_data0,
  output logic [DEF_CMD_W-1:0] o_cntr_data1,
  output logic [1:0]           o_cntr_valid,
  input  logic [1:0]           i_cntrtr_ready,
  output logic [1:0]           o_busy
);

  localparam int TMR_W = $clog2(POLL_DIV);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(POLL_DIV - 1);

  logic [1:0]           fifo_push_s, fifo_pop_s, fifo_empty_s, fifo_full_s;
  logic [DEF_CMD_W-1:0] fifo_rdata_s [2];
  logic [DEF_CMD_W-1:0] cntr_data_s  [2];
  logic [1:0]           poll_pend_s, poll_clr_s;
  logic                 drop_q;

  assign fifo_push_s = {i_cmd_wr & i_cmd_ch, i_cmd_wr & ~i_cmd_ch};

  // Discarded-write pulse, judged against the full flag visible at the write edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= i_cmd_wr & fifo_full_s[i_cmd_ch];
    end
  end

`ifdef DEF_POLL_EN
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       poll_pend_q, poll_pend_d;
  logic             ovr_q, ovr_d, tick_s;

  // Poll timer and pending bits; a new tick wins over a same-edge clear
  always_comb begin
    tick_s      = i_poll_en & (tmr_q == TMR_MAX);
    tmr_d       = i_poll_en ? (tick_s ? {TMR_W{1'b0}} : tmr_q + TMR_ONE) : tmr_q;
    poll_pend_d = tick_s ? 2'b11 : (poll_pend_q & ~poll_clr_s);
    ovr_d       = tick_s & (|poll_pend_q);
  end

  // Timer, pending and overrun registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q       <= {TMR_W{1'b0}};
      poll_pend_q <= 2'b00;
      ovr_q       <= 1'b0;
    end else begin
      tmr_q       <= tmr_d;
      poll_pend_q <= poll_pend_d;
      ovr_q       <= ovr_d;
    end
  end

  assign poll_pend_s = poll_pend_q;
  assign o_poll_ovr  = ovr_q;
`else
  logic unused_poll;
  assign unused_poll = ^{i_poll_en, poll_clr_s, TMR_MAX};
  assign poll_pend_s = 2'b00;
  assign o_poll_ovr  = 1'b0;
`endif

  for (genvar c = 0; c < 2; c++) begin : g_ch
    sched_st_t            state_q, state_d;
    sched_src_t           cur_src_q, cur_src_d, last_src_q, last_src_d;
    logic                 valid_q, valid_d;
    logic [DEF_CMD_W-1:0] data_q, data_d;
    logic                 host_rdy_s, pop_s, clr_s;

    def_cmd_fifo #(.W(DEF_CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (fifo_push_s[c]),
      .pop_i   (fifo_pop_s[c]),
      .wdata_i (i_cmd_data),
      .rdata_o (fifo_rdata_s[c]),
      .empty_o (fifo_empty_s[c]),
      .full_o  (fifo_full_s[c])
    );

    assign host_rdy_s = ~fifo_empty_s[c];

    // Issue FSM: load a source in IDLE, hold until the transmitter accepts in ISSUE
    always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      data_d     = data_q;
      cur_src_d  = cur_src_q;
      last_src_d = last_src_q;
      pop_s      = 1'b0;
      clr_s      = 1'b0;
      case (state_q)
        IDLE: begin
          if (host_rdy_s && (!poll_pend_s[c] || last_src_q == SRC_POLL)) begin
            data_d    = fifo_rdata_s[c];
            cur_src_d = SRC_HOST;
            valid_d   = 1'b1;
            state_d   = ISSUE;
          end else if (poll_pend_s[c]) begin
            data_d    = POLL_CMD;
            cur_src_d = SRC_POLL;
            valid_d   = 1'b1;
            state_d   = ISSUE;
          end else begin
            state_d   = IDLE;
          end
        end
        ISSUE: begin
          if (valid_q && i_cntrtr_ready[c]) begin
            valid_d    = 1'b0;
            last_src_d = cur_src_q;
            state_d    = IDLE;
            if (cur_src_q == SRC_HOST) begin
              pop_s = 1'b1;
            end else begin
              clr_s = 1'b1;
            end
          end else begin
            state_d = ISSUE;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end

    // FSM registers; last_src starts at poll so the host is served first
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q    <= IDLE;
        valid_q    <= 1'b0;
        data_q     <= {DEF_CMD_W{1'b0}};
        cur_src_q  <= SRC_HOST;
        last_src_q <= SRC_POLL;
      end else begin
        state_q    <= state_d;
        valid_q    <= valid_d;
        data_q     <= data_d;
        cur_src_q  <= cur_src_d;
        last_src_q <= last_src_d;
      end
    end

    assign fifo_pop_s[c]   = pop_s;
    assign poll_clr_s[c]   = clr_s;
    assign cntr_data_s[c]  = data_q;
    assign o_cntr_valid[c] = valid_q;
    assign o_busy[c]       = host_rdy_s | poll_pend_s[c] | valid_q;
  end

  assign o_cmd_full   = fifo_full_s;
  assign o_drop       = drop_q;
  assign o_cntr_data0 = cntr_data_s[0];
  assign o_cntr_data1 = cntr_data_s[1];

endmodule

// File: tb/tb_def_cmd_sched.sv
// Directed self-checking bench for def_cmd_sched; poll scenarios follow the DEF_POLL_EN build.
module tb_def_cmd_sched;

  localparam logic [31:0] PCMD = 32'hA500_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_wr = 1'b0;
  logic        cmd_ch = 1'b0;
  logic [31:0] cmd_data = 32'h0;
  logic        poll_en = 1'b0;
  logic [1:0]  ready = 2'b00;
  logic [1:0]  cmd_full, cntr_valid, busy;
  logic        drop, poll_ovr;
  logic [31:0] d0, d1;

  int n_checks = 0;
  int n_fail = 0;

  def_cmd_sched #(.FIFO_DEPTH(8), .POLL_DIV(16), .POLL_CMD(PCMD)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_cmd_wr       (cmd_wr),
    .i_cmd_ch       (cmd_ch),
    .i_cmd_data     (cmd_data),
    .o_cmd_full     (cmd_full),
    .o_drop         (drop),
    .i_poll_en      (poll_en),
    .o_poll_ovr     (poll_ovr),
    .o_cntr_data0   (d0),
    .o_cntr_data1   (d1),
    .o_cntr_valid   (cntr_valid),
    .i_cntrtr_ready (ready),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic ch, input logic [31:0] data);
    cmd_wr = 1'b1; cmd_ch = ch; cmd_data = data;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_checks++;
    if ({cntr_valid, cmd_full, busy, drop, poll_ovr} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000000", {cntr_valid, cmd_full, busy, drop, poll_ovr});
    end
    n_checks++;
    if ({d0, d1} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {d0, d1});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy_after_release: got %b expected 00", busy);
    end
  endtask

  task automatic test_single_write();
    ready = 2'b01;
    write(1'b0, 32'h1234_5678);
    n_checks++;
    if (cntr_valid !== 2'b00) begin
      n_fail++; $display("FAIL single_latency: got valid %b expected 00", cntr_valid);
    end
    n_checks++;
    if (busy !== 2'b01) begin
      n_fail++; $display("FAIL single_busy: got %b expected 01", busy);
    end
    tick();
    n_checks++;
    if (cntr_valid !== 2'b01) begin
      n_fail++; $display("FAIL single_valid: got %b expected 01", cntr_valid);
    end
    n_checks++;
    if (d0 !== 32'h1234_5678) begin
      n_fail++; $display("FAIL single_data: got %h expected 12345678", d0);
    end
    tick();
    n_checks++;
    if ({cntr_valid, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL single_done: got valid/busy %b expected 0000", {cntr_valid, busy});
    end
    ready = 2'b00;
  endtask

  task automatic test_ready_idle();
    ready = 2'b11;
    repeat (3) tick();
    n_checks++;
    if ({cntr_valid, busy, cmd_full} !== 6'b000000) begin
      n_fail++; $display("FAIL ready_idle: got %b expected 000000", {cntr_valid, busy, cmd_full});
    end
    ready = 2'b00;
  endtask

  task automatic test_overflow();
    int got;
    int last_cyc;
    for (int i = 1; i <= 7; i++) write(1'b1, 32'(i));
    n_checks++;
    if (cmd_full !== 2'b00) begin
      n_fail++; $display("FAIL ovf_full_early: got %b expected 00", cmd_full);
    end
    write(1'b1, 32'd8);
    n_checks++;
    if ({cmd_full, drop} !== 3'b100) begin
      n_fail++; $display("FAIL ovf_full_8th: got full/drop %b expected 100", {cmd_full, drop});
    end
    write(1'b1, 32'd9);
    n_checks++;
    if (drop !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drop_pulse: got %b expected 1", drop);
    end
    tick();
    n_checks++;
    if ({drop, cmd_full, cntr_valid} !== 5'b01010) begin
      n_fail++; $display("FAIL ovf_hold: got drop/full/valid %b expected 01010", {drop, cmd_full, cntr_valid});
    end
    ready = 2'b10;
    got = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 1) begin
        n_checks++;
        if (cmd_full !== 2'b00) begin
          n_fail++; $display("FAIL ovf_full_clear: got %b expected 00", cmd_full);
        end
      end
      if (cntr_valid[1]) begin
        n_checks++;
        if (d1 !== 32'(got + 1)) begin
          n_fail++; $display("FAIL ovf_order: got %0d expected %0d", d1, got + 1);
        end
        if (got > 0) begin
          n_checks++;
          if (cyc - last_cyc !== 2) begin
            n_fail++; $display("FAIL ovf_spacing: got %0d expected 2", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      tick();
    end
    n_checks++;
    if (got !== 8) begin
      n_fail++; $display("FAIL ovf_count: got %0d expected 8", got);
    end
    n_checks++;
    if (busy !== 2'b00) begin
      n_fail++; $display("FAIL ovf_busy_end: got %b expected 00", busy);
    end
    ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    write(1'b0, 32'hAAAA_0001);
    write(1'b1, 32'hBBBB_0002);
    tick();
    n_checks++;
    if (cntr_valid !== 2'b11) begin
      n_fail++; $display("FAIL dual_valid: got %b expected 11", cntr_valid);
    end
    n_checks++;
    if ({d0, d1} !== {32'hAAAA_0001, 32'hBBBB_0002}) begin
      n_fail++; $display("FAIL dual_data: got %h expected aaaa0001bbbb0002", {d0, d1});
    end
    ready = 2'b11;
    tick();
    n_checks++;
    if ({cntr_valid, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL dual_same_edge: got valid/busy %b expected 0000", {cntr_valid, busy});
    end
    ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int i = 0; i < 4; i++) write(1'b0, 32'hC0DE_0000 + 32'(i));
    n_checks++;
    if (cntr_valid !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_issue: got %b expected 01", cntr_valid);
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cntr_valid, busy, cmd_full} !== 6'b000000) begin
      n_fail++; $display("FAIL rst_mid_async: got %b expected 000000", {cntr_valid, busy, cmd_full});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    ready = 2'b11;
    seen = 0;
    repeat (10) begin
      tick();
      if (cntr_valid !== 2'b00) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL rst_mid_stale: got %0d valid cycles expected 0", seen);
    end
    n_checks++;
    if (busy !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_busy: got %b expected 00", busy);
    end
    ready = 2'b00;
  endtask

`ifdef DEF_POLL_EN
  task automatic test_poll_arb();
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] exp0 [4];
    exp0 = '{32'hB000_0001, PCMD, 32'hB000_0002, 32'hB000_0003};
    for (int i = 1; i <= 3; i++) write(1'b0, 32'hB000_0000 + 32'(i));
    poll_en = 1'b1;
    repeat (16) tick();
    poll_en = 1'b0;
    n_checks++;
    if ({busy, cntr_valid, poll_ovr} !== 5'b11010) begin
      n_fail++; $display("FAIL arb_pending: got busy/valid/ovr %b expected 11010", {busy, cntr_valid, poll_ovr});
    end
    ready = 2'b11;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cntr_valid[0]) q0.push_back(d0);
      if (cntr_valid[1]) q1.push_back(d1);
      tick();
    end
    n_checks++;
    if (q0.size() !== 4) begin
      n_fail++; $display("FAIL arb_ch0_count: got %0d expected 4", q0.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < q0.size()) begin
        n_checks++;
        if (q0[i] !== exp0[i]) begin
          n_fail++; $display("FAIL arb_ch0_order[%0d]: got %h expected %h", i, q0[i], exp0[i]);
        end
      end
    end
    n_checks++;
    if (q1.size() !== 1 || q1[0] !== PCMD) begin
      n_fail++; $display("FAIL arb_ch1_poll: got %0d words first %h expected 1 word %h", q1.size(), q1.size() > 0 ? q1[0] : 32'h0, PCMD);
    end
    ready = 2'b00;
  endtask

  task automatic test_poll_overrun();
    int ovr_cnt;
    int ovr_at;
    int n0;
    int n1;
    ovr_cnt = 0;
    ovr_at = -1;
    poll_en = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (poll_ovr) begin
        ovr_cnt++;
        ovr_at = cyc;
      end
    end
    poll_en = 1'b0;
    n_checks++;
    if (ovr_cnt !== 1 || ovr_at !== 32) begin
      n_fail++; $display("FAIL ovr_pulse: got %0d pulses at cycle %0d expected 1 at 32", ovr_cnt, ovr_at);
    end
    n_checks++;
    if ({cntr_valid, d0, d1} !== {2'b11, PCMD, PCMD}) begin
      n_fail++; $display("FAIL ovr_issue: got %b %h %h expected 11 %h %h", cntr_valid, d0, d1, PCMD, PCMD);
    end
    ready = 2'b11;
    n0 = 0;
    n1 = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cntr_valid[0]) n0++;
      if (cntr_valid[1]) n1++;
      tick();
    end
    n_checks++;
    if (n0 !== 1 || n1 !== 1) begin
      n_fail++; $display("FAIL ovr_single_poll: got %0d/%0d words expected 1/1", n0, n1);
    end
    n_checks++;
    if (busy !== 2'b00) begin
      n_fail++; $display("FAIL ovr_busy_end: got %b expected 00", busy);
    end
    ready = 2'b00;
  endtask
`else
  task automatic test_no_poll();
    logic [31:0] q0 [$];
    int n1;
    int ovr_cnt;
    n1 = 0;
    ovr_cnt = 0;
    for (int i = 1; i <= 3; i++) write(1'b0, 32'hB000_0000 + 32'(i));
    poll_en = 1'b1;
    repeat (20) begin
      tick();
      if (poll_ovr) ovr_cnt++;
    end
    poll_en = 1'b0;
    ready = 2'b11;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cntr_valid[0]) q0.push_back(d0);
      if (cntr_valid[1]) n1++;
      if (poll_ovr) ovr_cnt++;
      tick();
    end
    n_checks++;
    if (q0.size() !== 3) begin
      n_fail++; $display("FAIL nopoll_count: got %0d expected 3", q0.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < q0.size()) begin
        n_checks++;
        if (q0[i] !== 32'hB000_0001 + 32'(i)) begin
          n_fail++; $display("FAIL nopoll_order[%0d]: got %h expected %h", i, q0[i], 32'hB000_0001 + 32'(i));
        end
      end
    end
    n_checks++;
    if (n1 !== 0 || ovr_cnt !== 0) begin
      n_fail++; $display("FAIL nopoll_quiet: got ch1 %0d ovr %0d expected 0 0", n1, ovr_cnt);
    end
    ready = 2'b00;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_ready_idle();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef DEF_POLL_EN
    test_poll_arb();
    test_poll_overrun();
`else
    test_no_poll();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
